// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encoding,
// memory geometry and the latched-request record.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int MEM_AW = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [1:0]        off;
    logic [MEM_AW-1:0] waddr;
    logic [DATA_W-1:0] data;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: request legality check, load extract/extend
// and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic              chk_we_i,
  input  logic [2:0]        chk_funct3_i,
  input  logic [31:0]       chk_addr_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  output logic              err_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merged_o
);

  logic       legal;
  logic       misalign;
  logic       out_of_range;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  always_comb begin
    legal = 1'b0;
    case (chk_funct3_i)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !chk_we_i;
      default:          legal = 1'b0;
    endcase
    misalign = ((chk_funct3_i[1:0] == 2'b01) && chk_addr_i[0]) ||
               ((chk_funct3_i[1:0] == 2'b10) && (chk_addr_i[1:0] != 2'b00));
    out_of_range = |chk_addr_i[31:MEM_AW+2];
    err_o = !legal || misalign || out_of_range;
  end

  always_comb begin
    lane_b = word_i[7:0];
    case (off_i)
      2'd0: lane_b = word_i[7:0];
      2'd1: lane_b = word_i[15:8];
      2'd2: lane_b = word_i[23:16];
      2'd3: lane_b = word_i[31:24];
      default: lane_b = word_i[7:0];
    endcase
    lane_h = off_i[1] ? word_i[31:16] : word_i[15:0];

    load_data_o = word_i;
    case (funct3_i)
      F3_B:  load_data_o = {{24{lane_b[7]}}, lane_b};
      F3_BU: load_data_o = {24'h0, lane_b};
      F3_H:  load_data_o = {{16{lane_h[15]}}, lane_h};
      F3_HU: load_data_o = {16'h0, lane_h};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (off_i)
          2'd0: merged_o[7:0]   = wdata_i[7:0];
          2'd1: merged_o[15:8]  = wdata_i[7:0];
          2'd2: merged_o[23:16] = wdata_i[7:0];
          2'd3: merged_o[31:24] = wdata_i[7:0];
          default: merged_o = word_i;
        endcase
      end
      F3_H: begin
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RISC-V loads/stores into word
// accesses on a synchronous-write, combinational-read data memory.
//
// state   | meaning
// IDLE    | ready for a request
// READ    | memory word being read (load result or RMW source)
// WRITE   | one-cycle memory write of full or merged word
// RESP    | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              chk_err;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  lsu_align u_align (
    .chk_we_i     (req_we),
    .chk_funct3_i (req_funct3),
    .chk_addr_i   (req_addr),
    .word_i       (mem_rdata),
    .wdata_i      (req_q.data),
    .off_i        (req_q.off),
    .funct3_i     (req_q.funct3),
    .err_o        (chk_err),
    .load_data_o  (load_data),
    .merged_o     (merged)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d.we     = req_we;
          req_d.funct3 = req_funct3;
          req_d.off    = req_addr[1:0];
          req_d.waddr  = req_addr[MEM_AW+1:2];
          req_d.data   = req_wdata;
          resp_rdata_d = '0;
          resp_err_d   = chk_err;
          if (chk_err)                          state_d = S_RESP;
          else if (req_we && req_funct3 == F3_W) state_d = S_WRITE;
          else                                  state_d = S_READ;
        end
      end
      S_READ: begin
        if (req_q.we) begin
          req_d.data = merged;
          state_d    = S_WRITE;
        end else begin
          resp_rdata_d = load_data;
          state_d      = S_RESP;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory port is driven only while an access is in flight, zero otherwise.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = (state_q == S_READ || state_q == S_WRITE) ? req_q.waddr : '0;
  assign mem_we     = (state_q == S_WRITE) && !rst;
  assign mem_wdata  = (state_q == S_WRITE) ? req_q.data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against
// a byte-lane arithmetic model of memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected outcome of one request from byte-lane arithmetic on ref_mem.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd,
                       output int lat, output int nw, output logic [31:0] wword);
    bit legal;
    int widx;
    int sh;
    logic [31:0] w, b, h, mask;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e = !legal || (addr >= 32'd4096);
    if (f3[1:0] == 2'd1 && (addr % 2) != 0) e = 1'b1;
    if (f3[1:0] == 2'd2 && (addr % 4) != 0) e = 1'b1;
    widx = int'((addr / 4) % 1024);
    w = ref_mem[widx];
    sh = int'(addr % 4) * 8;
    b = (w >> sh) & 32'hFF;
    h = (w >> sh) & 32'hFFFF;
    rd = 0; nw = 0; wword = 0;
    if (e) lat = 1;
    else if (!we) begin
      lat = 2;
      case (f3)
        3'd0: rd = (b >= 128) ? b - 32'd256 : b;
        3'd4: rd = b;
        3'd1: rd = (h >= 32768) ? h - 32'd65536 : h;
        3'd5: rd = h;
        default: rd = w;
      endcase
    end else begin
      nw = 1;
      lat = (f3 == 3'd2) ? 2 : 3;
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      wword = (w & ~(mask << sh)) | ((wd & mask) << sh);
      ref_mem[widx] = wword;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    logic e_exp, got_err;
    logic [31:0] rd_exp, w_exp, got_rd, got_wd;
    logic [9:0] got_wa;
    int lat_exp, nw_exp, lat, nw;
    bit got;
    model(we, f3, addr, wd, e_exp, rd_exp, lat_exp, nw_exp, w_exp);
    @(negedge clk);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, " idle_resp"}, {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0; lat = 0; nw = 0; got_rd = 0; got_err = 0; got_wa = 0; got_wd = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we) begin nw++; got_wa = mem_addr; got_wd = mem_wdata; end
      if (resp_valid) begin got = 1; lat = c; got_rd = resp_rdata; got_err = resp_err; end
    end
    chk({tag, " latency"}, lat, lat_exp);
    chk({tag, " err"}, {31'b0, got_err}, {31'b0, e_exp});
    chk({tag, " rdata"}, got_rd, rd_exp);
    chk({tag, " writes"}, nw, nw_exp);
    if (nw_exp != 0) begin
      chk({tag, " waddr"}, {22'b0, got_wa}, (addr / 4) % 1024);
      chk({tag, " wdata"}, got_wd, w_exp);
    end
  endtask

  logic [2:0]  b2b_f3 [3];
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp [3];
  int acc_cyc [3];

  initial begin
    logic e_tmp;
    logic [31:0] w_tmp, a;
    int l_tmp, n_tmp, n_acc, n_resp;
    logic [2:0] f;
    for (int i = 0; i < 1024; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst ready", {31'b0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;

    do_req(1, 3'b010, 32'h000, 32'hDEADBEEF, "sw0");
    do_req(0, 3'b000, 32'h003, 0, "lb3");
    do_req(0, 3'b100, 32'h003, 0, "lbu3");
    do_req(0, 3'b001, 32'h002, 0, "lh2");
    do_req(0, 3'b101, 32'h000, 0, "lhu0");
    do_req(0, 3'b010, 32'h000, 0, "lw0");
    do_req(1, 3'b000, 32'h001, 32'h00000055, "sb1");
    do_req(1, 3'b001, 32'h00A, 32'h00001234, "sh10");
    do_req(0, 3'b010, 32'h008, 0, "lw8");
    do_req(0, 3'b010, 32'h000, 0, "lw0b");
    chk("word2 value", mem[2], 32'h12340000);
    chk("word0 value", mem[0], 32'hDEAD55EF);
    do_req(1, 3'b001, 32'h003, 32'h1111, "sh3 err");
    do_req(0, 3'b010, 32'h00001000, 0, "lw range err");
    do_req(0, 3'b011, 32'h000, 0, "f3 011 err");

    // reset landing in the WRITE cycle of a byte store
    @(negedge clk);
    chk("rstw ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h001; req_wdata = 32'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw in write", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1 chk("rstw we gated", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    chk("rstw word0", mem[0], ref_mem[0]);
    chk("rstw ready low", {31'b0, req_ready}, 32'd0);
    chk("rstw resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstw mem_we", {31'b0, mem_we}, 32'd0);
    chk("rstw mem_addr", {22'b0, mem_addr}, 32'd0);
    chk("rstw mem_wdata", mem_wdata, 32'd0);
    chk("rstw rdata", resp_rdata, 32'd0);
    chk("rstw err", {31'b0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw ready after", {31'b0, req_ready}, 32'd1);
    chk("rstw word0 kept", mem[0], 32'hDEAD55EF);

    // three loads with req_valid held high
    b2b_f3[0] = 3'b010; b2b_addr[0] = 32'h000;
    b2b_f3[1] = 3'b100; b2b_addr[1] = 32'h00B;
    b2b_f3[2] = 3'b001; b2b_addr[2] = 32'h002;
    for (int i = 0; i < 3; i++)
      model(0, b2b_f3[i], b2b_addr[i], 0, e_tmp, b2b_exp[i], l_tmp, n_tmp, w_tmp);
    n_acc = 0; n_resp = 0;
    for (int c = 0; c < 40 && n_resp < 3; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        chk("b2b rdata", resp_rdata, b2b_exp[n_resp]);
        n_resp++;
      end
      chk("b2b ready", {31'b0, req_ready}, {31'b0, (n_acc == n_resp) && !resp_valid});
      if (n_acc < 3) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = b2b_f3[n_acc]; req_addr = b2b_addr[n_acc];
      end else req_valid = 1'b0;
      if (req_ready && n_acc < 3) begin acc_cyc[n_acc] = c; n_acc++; end
    end
    req_valid = 1'b0;
    chk("b2b responses", n_resp, 3);
    chk("b2b spacing 1", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b spacing 2", acc_cyc[2] - acc_cyc[1], 3);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      f = 3'($urandom_range(0, 7));
      do_req(1'($urandom_range(0, 1)), f, a, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
